// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 8-bit combinational ALU: buffers commands in a FIFO,
// drives registered operands, captures the result and returns it over valid/ready.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_sel,
  input  logic             cmd_chain,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_illegal,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = 20;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state;
  logic [7:0]    acc;

  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [7:0]    head_a;
  logic [7:0]    head_b;
  logic [2:0]    head_sel;
  logic          head_chain;

  assign fifo_nonempty = (count != '0);
  assign cmd_ready     = (count != FULL);
  assign push          = cmd_valid && cmd_ready;
  // A pop happens from IDLE, or on the RESP handshake edge so results stream every 2 cycles
  assign pop           = fifo_nonempty &&
                         ((state == S_IDLE) ||
                          ((state == S_RESP) && res_valid && res_ready));
  assign busy          = (state != S_IDLE) || fifo_nonempty;

  assign head       = mem[rd_ptr];
  assign head_a     = head[19:12];
  assign head_b     = head[11:4];
  assign head_sel   = head[3:1];
  assign head_chain = head[0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel, cmd_chain};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_illegal <= 1'b0;
      acc         <= '0;
      op_count    <= '0;
    end else begin
      // Chained commands resolve operand A from the latest capture, accepted or not
      if (pop) begin
        alu_a   <= head_chain ? acc : head_a;
        alu_b   <= head_b;
        alu_sel <= head_sel;
      end
      case (state)
        S_IDLE: begin
          if (pop) state <= S_DRIVE;
        end
        S_DRIVE: begin
          res_data    <= alu_result;
          acc         <= alu_result;
          res_illegal <= (alu_sel > 3'd4);
          res_valid   <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= pop ? S_DRIVE : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU attached to the alu_* port.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_sel;
  logic        cmd_chain;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_illegal;
  logic        busy;
  logic [15:0] op_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sel     (cmd_sel),
    .cmd_chain   (cmd_chain),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_illegal (res_illegal),
    .busy        (busy),
    .op_count    (op_count)
  );

  always_comb begin
    case (alu_sel)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = ~alu_a;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sel, input logic chain);
    logic ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    cmd_chain = chain;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!ok) check("push_timeout", 32'(ok), 32'd1);
  endtask

  // Waits for res_valid, records the result, returns after the handshake edge.
  task automatic get_result(output logic [7:0] data, output logic ill);
    logic seen;
    seen      = 1'b0;
    data      = '0;
    ill       = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        data = res_data;
        ill  = res_illegal;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    if (!seen) check("res_timeout", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [7:0] d;
    logic       il;
    int unsigned acc_n;
    int unsigned got_n;
    int unsigned last_cyc;
    logic        stray;
    logic [7:0]  exp_full [5];

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    cmd_chain = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single add with latency check
    push_cmd(8'h05, 8'h03, 3'd0, 1'b0);
    check("add_busy",      32'(busy),      32'd1);
    check("add_valid_t0",  32'(res_valid), 32'd0);
    @(negedge clk);
    check("add_drive_a",   32'(alu_a),     32'h05);
    check("add_drive_b",   32'(alu_b),     32'h03);
    check("add_valid_t1",  32'(res_valid), 32'd0);
    @(negedge clk);
    check("add_valid_t2",  32'(res_valid), 32'd1);
    check("add_data",      32'(res_data),  32'h08);
    check("add_illegal",   32'(res_illegal), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("add_valid_done", 32'(res_valid), 32'd0);
    check("add_op_count",  32'(op_count),  32'd1);
    check("add_idle",      32'(busy),      32'd0);

    // Sub wrap then not-a, in order
    push_cmd(8'h03, 8'h05, 3'd1, 1'b0);
    push_cmd(8'hF0, 8'h00, 3'd4, 1'b0);
    get_result(d, il);
    check("sub_wrap", 32'(d), 32'hFE);
    get_result(d, il);
    check("not_a",    32'(d), 32'h0F);

    // Chained or takes operand A from the previous result
    push_cmd(8'h10, 8'h20, 3'd0, 1'b0);
    push_cmd(8'hAA, 8'h0F, 3'd3, 1'b1);
    get_result(d, il);
    check("chain_first",   32'(d),       32'h30);
    check("chain_drive_a", 32'(alu_a),   32'h30);
    check("chain_drive_s", 32'(alu_sel), 32'd3);
    get_result(d, il);
    check("chain_second",  32'(d),       32'h3F);
    check("op_count_5",    32'(op_count), 32'd5);

    // Fill with res_ready low: DEPTH+1 accepted
    exp_full = '{8'h20, 8'h22, 8'h24, 8'h26, 8'h28};
    acc_n = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = 1'b1;
      cmd_a     = 8'(8'h20 + acc_n);
      cmd_b     = 8'(acc_n);
      cmd_sel   = 3'd0;
      cmd_chain = 1'b0;
      if (cmd_ready) begin
        @(negedge clk);
        acc_n++;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    check("full_accepted",  acc_n,           5);
    check("full_cmd_ready", 32'(cmd_ready),  32'd0);
    res_ready = 1'b1;
    got_n     = 0;
    last_cyc  = 0;
    for (int c = 0; c < 40 && got_n < 5; c++) begin
      if (res_valid) begin
        check($sformatf("full_res%0d", got_n), 32'(res_data), 32'(exp_full[got_n]));
        if (got_n > 0) check($sformatf("full_gap%0d", got_n), c - last_cyc, 2);
        last_cyc = c;
        got_n++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    check("full_got",      got_n,           5);
    check("full_busy_end", 32'(busy),       32'd0);
    check("op_count_10",   32'(op_count),   32'd10);

    // Illegal opcode forwarded and flagged
    push_cmd(8'h10, 8'h01, 3'd6, 1'b0);
    get_result(d, il);
    check("ill_data", 32'(d),  32'h11);
    check("ill_flag", 32'(il), 32'd1);
    check("ill_sel",  32'(alu_sel), 32'd6);

    // Reset while in DRIVE with two entries queued
    push_cmd(8'h01, 8'h01, 3'd0, 1'b0);
    push_cmd(8'h02, 8'h02, 3'd0, 1'b0);
    push_cmd(8'h03, 8'h03, 3'd0, 1'b0);
    push_cmd(8'h04, 8'h04, 3'd0, 1'b0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("mid_drive_a", 32'(alu_a), 32'h02);
    check("mid_busy",    32'(busy),  32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(res_valid), 32'd0);
    check("mid_rst_data",   32'(res_data),  32'd0);
    check("mid_rst_alu_a",  32'(alu_a),     32'd0);
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_opcnt",  32'(op_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_valid) stray = 1'b1;
    end
    check("post_rst_no_valid", 32'(stray),     32'd0);
    check("post_rst_busy",     32'(busy),      32'd0);
    check("post_rst_ready",    32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Sequential initiator that drives the team's 8-bit combinational ALU (ops: add, sub, and, or, not-a).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU through registered operand/select outputs, captures the ALU result one cycle later, and returns it over a valid/ready response interface with backpressure.
- Supports chained operations: operand A is taken from the previous result, for multi-step computations without host round-trips.

Parameters:
- DEPTH, 4, command FIFO depth in entries (power of 2, minimum 2).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; high when FIFO not full
- cmd_a  input  8  operand A (ignored when cmd_chain=1)
- cmd_b  input  8  operand B
- cmd_sel  input  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 not-a
- cmd_chain  input  1  1 = use last captured result as operand A
- alu_a  output  8  registered operand A to ALU
- alu_b  output  8  registered operand B to ALU
- alu_sel  output  3  registered opcode to ALU
- alu_result  input  8  combinational ALU output, valid in the same cycle as alu_a/alu_b/alu_sel
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  8  captured result
- res_illegal  output  1  captured command had opcode 101-111
- busy  output  1  FSM not IDLE or FIFO not empty
- op_count  output  CNT_W  results delivered since reset, wraps

Behaviour:
- Reset (async, rst_n=0): FIFO empty, FSM=IDLE, alu_a/alu_b/alu_sel=0, res_valid=0, res_data=0, res_illegal=0, accumulator=0, op_count=0, busy=0. cmd_ready=1 once reset is released.
- FIFO push: on a clock edge with cmd_valid && cmd_ready; stores {a, b, sel, chain}.
- FSM states:
  - IDLE: if FIFO not empty, pop head at the edge, load the alu_* registers, go to DRIVE.
  - DRIVE: at the edge, res_data<=alu_result, accumulator<=alu_result, res_illegal<=(alu_sel>4), res_valid<=1, go to RESP.
  - RESP: hold res_data/res_illegal stable while res_valid && !res_ready. On res_valid && res_ready at the edge: res_valid<=0 and op_count++ (wraps to 0). In that same edge, if FIFO not empty, pop and go to DRIVE; otherwise go to IDLE.
- Chain resolution at pop time: alu_a<=(chain ? accumulator : a). The accumulator always holds the most recently captured result, including results not yet accepted.
- Latency: command pushed at edge T into an empty, idle block → popped at T+1 → res_valid high after T+2. Sustained throughput is 1 result per 2 cycles with res_ready held high.
- Simultaneous push and pop on a full FIFO: cmd_ready is computed from the current count, so no push occurs when full. Push and pop in the same cycle on a non-full FIFO keeps the count unchanged.
- Illegal opcodes are forwarded unchanged to the ALU (ALU treats them as add). res_illegal is reported; no other effect.
- Capacity with res_ready held low: one result held in RESP plus DEPTH entries in the FIFO, so DEPTH+1 commands are accepted, then cmd_ready=0.
- Reset mid-operation: all state cleared immediately. The pending result and FIFO contents are discarded; no res_valid pulse follows.
- alu_* registers hold their last values in IDLE and RESP; they change only on a pop.

Test Plan:
- Single add: push a=0x05, b=0x03, sel=000 → res_valid rises 2 edges after acceptance with res_data=0x08, res_illegal=0; op_count=1 after handshake.
- Sub wrap and not: push 0x03-0x05 (sel 001), then a=0xF0 (sel 100) → res_data=0xFE then 0x0F, in order.
- Chain: push 0x10+0x20, then chain=1, b=0x0F, sel=011 → results 0x30, then 0x3F; alu_a=0x30 during the second DRIVE.
- Backpressure/full: res_ready=0, cmd_valid=1 continuously with DEPTH=4 → exactly 5 commands accepted, cmd_ready=0. Then res_ready=1 → 5 results in push order, one per 2 cycles, busy=0 at the end.
- Illegal opcode: a=0x10, b=0x01, sel=110 → res_data=0x11, res_illegal=1.
- Reset mid-op: assert rst_n=0 while in DRIVE with 2 entries in the FIFO → all outputs at reset values immediately; after release, no res_valid without new commands.
